// File: rtl/card_pkg.sv
// Shared types and constants for the card shoe dealer: modes, card values,
// LFSR taps and the fixed scripts replayed by the scripted modes.
package card_pkg;

    typedef enum logic [2:0] {
        MODE_BASE      = 3'd0,
        MODE_SIMPLE    = 3'd1,
        MODE_DOUBLE    = 3'd2,
        MODE_BLACKJACK = 3'd3,
        MODE_SPLIT     = 3'd4
    } mode_e;

    typedef logic [3:0] card_val_t;

    localparam card_val_t ACE      = 4'd1;
    localparam card_val_t FACE_VAL = 4'd10;
    localparam card_val_t RANK_MAX = 4'd13;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Indexed by mode value; unused rows pad illegal modes with empty cards
    localparam card_val_t SCRIPT [8][8] = '{
        '{4'd0,  4'd0,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
        '{4'd10, 4'd8,  4'd4, 4'd6, 4'd4, 4'd0, 4'd0, 4'd0},
        '{4'd10, 4'd8,  4'd6, 4'd8, 4'd2, 4'd0, 4'd0, 4'd0},
        '{4'd10, 4'd1,  4'd8, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0},
        '{4'd10, 4'd10, 4'd9, 4'd8, 4'd8, 4'd4, 4'd8, 4'd2},
        '{4'd0,  4'd0,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
        '{4'd0,  4'd0,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
        '{4'd0,  4'd0,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}
    };

    localparam logic [3:0] SCRIPT_LEN [8] = '{
        4'd0, 4'd5, 4'd5, 4'd4, 4'd8, 4'd0, 4'd0, 4'd0
    };

    function automatic logic mode_legal(input logic [2:0] m);
        return m <= MODE_SPLIT;
    endfunction

endpackage

// File: rtl/card_shoe_dealer_if.sv
// Request/response bundle between the game FSM (master) and the dealer (slave).
interface card_shoe_dealer_if #(
    parameter int NUM_OUT = 4,
    parameter int DECKS   = 1
);
    localparam int CNT_W  = $clog2(NUM_OUT + 1);
    localparam int LEFT_W = $clog2(52 * DECKS + 1);

    logic                  deal_req;
    logic [CNT_W-1:0]      deal_cnt;
    logic [2:0]            mode;
    logic [4*NUM_OUT-1:0]  cards;
    logic                  deal_valid;
    logic                  busy;
    logic                  reshuffled;
    logic [LEFT_W-1:0]     cards_left;

    modport master (
        output deal_req, deal_cnt, mode,
        input  cards, deal_valid, busy, reshuffled, cards_left
    );

    modport slave (
        input  deal_req, deal_cnt, mode,
        output cards, deal_valid, busy, reshuffled, cards_left
    );

endinterface

// File: rtl/card_lfsr16.sv
// Free-running 16-bit Galois LFSR; the low nibble is the rank candidate.
module card_lfsr16
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [3:0] nibble
);

    logic [15:0] state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SEED;
        else          state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end

    assign nibble = state[3:0];

endmodule

// File: rtl/card_shoe_dealer.sv
// Deals 1..NUM_OUT cards per request, either from a depleting multi-deck shoe
// sampled by an LFSR or from fixed per-mode scripts.
module card_shoe_dealer
    import card_pkg::*;
#(
    parameter int          NUM_OUT   = 4,
    parameter int          DECKS     = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_n,
    card_shoe_dealer_if.slave bus
);

    localparam int CNT_W  = $clog2(NUM_OUT + 1);
    localparam int LEFT_W = $clog2(52 * DECKS + 1);
    localparam int RANK_W = $clog2(4 * DECKS + 1);

    localparam logic [RANK_W-1:0] RANK_FULL = RANK_W'(4 * DECKS);
    localparam logic [LEFT_W-1:0] SHOE_FULL = LEFT_W'(52 * DECKS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_RESHUF = 3'd2,
        S_DRAW   = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e st, nxt;

    logic [NUM_OUT-1:0][3:0] cards;
    logic                    deal_valid;
    logic                    reshuffled;
    logic [LEFT_W-1:0]       cards_left;

    // Entries 0, 14 and 15 stay zero so the raw nibble can index directly
    logic [15:0][RANK_W-1:0] rank_cnt;
    logic [7:0][2:0]         ptr;
    logic [2:0]              lmode;
    logic [2:0]              prev_mode;
    logic [CNT_W-1:0]        n;
    logic [CNT_W-1:0]        idx;

    logic [3:0]  r;
    logic        accept, do_reshuf, take, finish;
    logic        base_ok;
    logic        is_base;
    card_val_t   draw_val;
    logic [2:0]  ptr_cur, ptr_nxt;
    logic [CNT_W-1:0] n_clamp;

    card_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .nibble  (r)
    );

    assign is_base  = (lmode == MODE_BASE);
    assign base_ok  = (r >= ACE) && (r <= RANK_MAX) && (rank_cnt[r] != '0);
    assign ptr_cur  = ptr[lmode];
    assign ptr_nxt  = ({1'b0, ptr_cur} == SCRIPT_LEN[lmode] - 4'd1) ? 3'd0 : ptr_cur + 3'd1;
    assign draw_val = is_base ? ((r > FACE_VAL) ? FACE_VAL : r) : SCRIPT[lmode][ptr_cur];

    always_comb begin
        n_clamp = bus.deal_cnt;
        if (bus.deal_cnt == '0)                      n_clamp = CNT_W'(1);
        else if (bus.deal_cnt > CNT_W'(NUM_OUT))     n_clamp = CNT_W'(NUM_OUT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) st <= S_IDLE;
        else          st <= nxt;
    end

    always_comb begin
        nxt       = st;
        accept    = 1'b0;
        do_reshuf = 1'b0;
        take      = 1'b0;
        finish    = 1'b0;
        case (st)
            S_IDLE: begin
                if (bus.deal_req) begin
                    accept = 1'b1;
                    nxt    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!mode_legal(lmode))                          nxt = S_DONE;
                else if (is_base && cards_left < LEFT_W'(n))     nxt = S_RESHUF;
                else                                             nxt = S_DRAW;
            end
            S_RESHUF: begin
                do_reshuf = 1'b1;
                nxt       = S_DRAW;
            end
            S_DRAW: begin
                take = !is_base || base_ok;
                if (take && (idx + CNT_W'(1)) == n) nxt = S_DONE;
            end
            S_DONE: begin
                finish = 1'b1;
                nxt    = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cards      <= '0;
            deal_valid <= 1'b0;
            reshuffled <= 1'b0;
            cards_left <= SHOE_FULL;
            for (int k = 0; k < 16; k++)
                rank_cnt[k] <= (k >= 1 && k <= 13) ? RANK_FULL : '0;
            ptr        <= '0;
            lmode      <= MODE_BASE;
            prev_mode  <= MODE_BASE;
            n          <= CNT_W'(1);
            idx        <= '0;
        end else begin
            deal_valid <= finish;
            reshuffled <= do_reshuf;

            if (accept) begin
                lmode <= bus.mode;
                n     <= n_clamp;
                idx   <= '0;
                cards <= '0;
                // An illegal request must leave the script history untouched
                if (mode_legal(bus.mode)) begin
                    prev_mode <= bus.mode;
                    if (bus.mode != prev_mode) ptr <= '0;
                end
            end

            if (do_reshuf) begin
                cards_left <= SHOE_FULL;
                for (int k = 0; k < 16; k++)
                    rank_cnt[k] <= (k >= 1 && k <= 13) ? RANK_FULL : '0;
            end

            if (take) begin
                cards[idx] <= draw_val;
                idx        <= idx + CNT_W'(1);
                if (is_base) begin
                    rank_cnt[r] <= rank_cnt[r] - RANK_W'(1);
                    cards_left  <= cards_left - LEFT_W'(1);
                end else begin
                    ptr[lmode] <= ptr_nxt;
                end
            end
        end
    end

    assign bus.cards      = cards;
    assign bus.deal_valid = deal_valid;
    assign bus.busy       = (st != S_IDLE);
    assign bus.reshuffled = reshuffled;
    assign bus.cards_left = cards_left;

endmodule

// File: tb/tb_card_shoe_dealer.sv
// Directed bench for card_shoe_dealer (NUM_OUT=4, DECKS=1).
module tb_card_shoe_dealer;

    localparam int LIM = 3000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    card_shoe_dealer_if #(.NUM_OUT(4), .DECKS(1)) bus ();

    card_shoe_dealer #(.NUM_OUT(4), .DECKS(1), .LFSR_SEED(16'hACE1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    int          split_cnt [7] = '{2, 2, 1, 1, 1, 1, 1};
    logic [15:0] split_exp [7] = '{16'h00AA, 16'h0089, 16'h0008, 16'h0004,
                                   16'h0008, 16'h0002, 16'h000A};

    task automatic do_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        bus.deal_req = 1'b0;
        bus.deal_cnt = '0;
        bus.mode     = 3'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue one request and wait for deal_valid; lat counts edges after acceptance
    task automatic deal(input logic [2:0] m, input int c, output int lat,
                        output bit resh, output logic [15:0] resh_cards);
        @(negedge clk);
        bus.mode     = m;
        bus.deal_cnt = 3'(c);
        bus.deal_req = 1'b1;
        @(posedge clk);
        #1 bus.deal_req = 1'b0;
        lat = 0; resh = 1'b0; resh_cards = '1;
        while (lat < LIM) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.reshuffled) begin
                resh = 1'b1;
                resh_cards = bus.cards;
            end
            if (bus.deal_valid) break;
        end
    endtask

    task automatic test_reset();
        int bad;
        @(negedge clk);
        reset_n      = 1'b0;
        bus.deal_req = 1'b0;
        bus.deal_cnt = '0;
        bus.mode     = 3'd0;
        repeat (2) @(negedge clk);
        vecs++; if (bus.cards !== 16'h0) begin errs++; $display("FAIL reset_cards got %h want 0000", bus.cards); end
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vecs++; if (bus.cards_left !== 6'd52) begin errs++; $display("FAIL reset_left got %0d want 52", bus.cards_left); end
        vecs++; if (bus.deal_valid !== 1'b0 || bus.reshuffled !== 1'b0) begin
            errs++; $display("FAIL reset_pulses got dv=%b rs=%b want 0/0", bus.deal_valid, bus.reshuffled); end
        reset_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.deal_valid !== 1'b0 || bus.reshuffled !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        vecs++; if (bad != 0) begin errs++; $display("FAIL post_reset_idle got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_split();
        int lat; bit resh; logic [15:0] rc;
        for (int k = 0; k < 7; k++) begin
            deal(3'd4, split_cnt[k], lat, resh, rc);
            vecs++; if (bus.cards !== split_exp[k]) begin
                errs++; $display("FAIL split_cards[%0d] got %h want %h", k, bus.cards, split_exp[k]); end
            vecs++; if (lat != split_cnt[k] + 2) begin
                errs++; $display("FAIL split_latency[%0d] got %0d want %0d", k, lat, split_cnt[k] + 2); end
        end
        vecs++; if (bus.cards_left !== 6'd52) begin
            errs++; $display("FAIL split_shoe_untouched got %0d want 52", bus.cards_left); end
    endtask

    task automatic test_clamp_handshake();
        int lat; bit resh; logic [15:0] rc; int extra;
        deal(3'd1, 0, lat, resh, rc);
        vecs++; if (bus.cards !== 16'h000A) begin errs++; $display("FAIL clamp_zero got %h want 000a", bus.cards); end
        vecs++; if (lat != 3) begin errs++; $display("FAIL clamp_zero_lat got %0d want 3", lat); end
        deal(3'd1, 7, lat, resh, rc);
        vecs++; if (bus.cards !== 16'h4648) begin errs++; $display("FAIL clamp_seven got %h want 4648", bus.cards); end
        vecs++; if (lat != 6) begin errs++; $display("FAIL clamp_seven_lat got %0d want 6", lat); end

        // Second pulse lands while busy with a different mode/count; both ignored
        @(negedge clk);
        bus.mode = 3'd1; bus.deal_cnt = 3'd4; bus.deal_req = 1'b1;
        @(negedge clk);
        bus.deal_req = 1'b0;
        @(negedge clk);
        bus.mode = 3'd3; bus.deal_cnt = 3'd1; bus.deal_req = 1'b1;
        @(negedge clk);
        bus.deal_req = 1'b0;
        lat = 0;
        while (lat < LIM && bus.deal_valid !== 1'b1) begin @(negedge clk); lat++; end
        vecs++; if (bus.deal_valid !== 1'b1) begin errs++; $display("FAIL busy_deal_timeout got 0 want deal_valid"); end
        vecs++; if (bus.cards !== 16'h648A) begin errs++; $display("FAIL busy_latched_cards got %h want 648a", bus.cards); end
        extra = 0;
        repeat (20) begin @(negedge clk); if (bus.deal_valid === 1'b1) extra++; end
        vecs++; if (extra != 0) begin errs++; $display("FAIL busy_pulse_ignored got %0d extra want 0", extra); end

        deal(3'd5, 2, lat, resh, rc);
        vecs++; if (bus.cards !== 16'h0 || lat >= LIM) begin
            errs++; $display("FAIL illegal_mode got %h lat %0d want 0000", bus.cards, lat); end
        deal(3'd1, 1, lat, resh, rc);
        vecs++; if (bus.cards !== 16'h0004) begin errs++; $display("FAIL illegal_keeps_ptr got %h want 0004", bus.cards); end
    endtask

    task automatic test_base_shoe();
        int lat; bit resh; logic [15:0] rc;
        int hist [16];
        int bad_lat, bad_slots, any_resh, bad_left;
        do_reset();
        for (int v = 0; v < 16; v++) hist[v] = 0;
        bad_lat = 0; bad_slots = 0; any_resh = 0; bad_left = 0;
        for (int k = 0; k < 52; k++) begin
            deal(3'd0, 1, lat, resh, rc);
            if (lat >= LIM || lat < 3) bad_lat++;
            if (bus.cards[15:4] !== 12'h0) bad_slots++;
            if (resh) any_resh++;
            if (bus.cards_left !== 6'(51 - k)) bad_left++;
            hist[bus.cards[3:0]]++;
        end
        vecs++; if (bad_lat != 0) begin errs++; $display("FAIL base_latency got %0d bad want 0", bad_lat); end
        vecs++; if (bad_slots != 0) begin errs++; $display("FAIL base_extra_slots got %0d bad want 0", bad_slots); end
        vecs++; if (any_resh != 0) begin errs++; $display("FAIL base_early_reshuffle got %0d want 0", any_resh); end
        vecs++; if (bad_left != 0) begin errs++; $display("FAIL base_left_track got %0d bad want 0", bad_left); end
        for (int v = 1; v <= 9; v++) begin
            vecs++; if (hist[v] != 4) begin errs++; $display("FAIL base_hist[%0d] got %0d want 4", v, hist[v]); end
        end
        vecs++; if (hist[10] != 16) begin errs++; $display("FAIL base_hist[10] got %0d want 16", hist[10]); end
        vecs++; if (bus.cards_left !== 6'd0) begin errs++; $display("FAIL base_empty got %0d want 0", bus.cards_left); end

        deal(3'd0, 1, lat, resh, rc);
        vecs++; if (!resh) begin errs++; $display("FAIL base_53_reshuffle got 0 want 1"); end
        vecs++; if (bus.cards_left !== 6'd51) begin errs++; $display("FAIL base_53_left got %0d want 51", bus.cards_left); end
        vecs++; if (bus.cards[3:0] === 4'h0 || bus.cards[3:0] > 4'd10) begin
            errs++; $display("FAIL base_53_card got %0d want 1..10", bus.cards[3:0]); end

        for (int k = 0; k < 50; k++) deal(3'd0, 1, lat, resh, rc);
        vecs++; if (bus.cards_left !== 6'd1) begin errs++; $display("FAIL base_one_left got %0d want 1", bus.cards_left); end
        deal(3'd0, 3, lat, resh, rc);
        vecs++; if (!resh || rc !== 16'h0) begin
            errs++; $display("FAIL low_reshuffle got resh=%b cards=%h want 1/0000", resh, rc); end
        vecs++; if (bus.cards[3:0] === 4'h0 || bus.cards[7:4] === 4'h0 || bus.cards[11:8] === 4'h0 || bus.cards[15:12] !== 4'h0) begin
            errs++; $display("FAIL low_three_cards got %h want three nonzero", bus.cards); end
        vecs++; if (bus.cards_left !== 6'd49) begin errs++; $display("FAIL low_left got %0d want 49", bus.cards_left); end
    endtask

    task automatic test_reset_mid_draw();
        int waited; int dv;
        do_reset();
        @(negedge clk);
        bus.mode = 3'd0; bus.deal_cnt = 3'd4; bus.deal_req = 1'b1;
        @(posedge clk);
        #1 bus.deal_req = 1'b0;
        waited = 0; dv = 0;
        while (waited < LIM && bus.cards_left !== 6'd50) begin
            @(posedge clk); #1; waited++;
            if (bus.deal_valid === 1'b1) dv++;
        end
        vecs++; if (bus.cards_left !== 6'd50 || dv != 0) begin
            errs++; $display("FAIL mid_two_accepts got left=%0d dv=%0d want 50/0", bus.cards_left, dv); end
        reset_n = 1'b0;
        #1;
        vecs++; if (bus.cards !== 16'h0 || bus.busy !== 1'b0) begin
            errs++; $display("FAIL mid_reset_outputs got cards=%h busy=%b want 0000/0", bus.cards, bus.busy); end
        vecs++; if (bus.cards_left !== 6'd52) begin errs++; $display("FAIL mid_reset_left got %0d want 52", bus.cards_left); end
        vecs++; if (dut.u_lfsr.state !== 16'hACE1) begin
            errs++; $display("FAIL mid_reset_lfsr got %h want ace1", dut.u_lfsr.state); end
        @(negedge clk);
        reset_n = 1'b1;
        dv = 0;
        repeat (12) begin @(negedge clk); if (bus.deal_valid !== 1'b0) dv++; end
        vecs++; if (dv != 0) begin errs++; $display("FAIL mid_no_valid got %0d pulses want 0", dv); end
    endtask

    initial begin
        bus.deal_req = 1'b0;
        bus.deal_cnt = '0;
        bus.mode     = 3'd0;
        test_reset();
        test_split();
        test_clamp_handshake();
        test_base_shoe();
        test_reset_mid_draw();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
